univ_shift_reg: RTL and testbench

Parametrised universal shift register and the successor to the fixed 4-bit serial-in/serial-out register. It supports bidirectional shift, rotate, parallel load and hold. It adds a burst engine that applies a latched shift or rotate operation for a programmed number of cycles, with busy/done status. It sits between serial links and parallel datapaths as the common serialiser/deserialiser/barrel-step primitive.

---
 rtl/univ_shift_pkg.sv | 16 +
 rtl/univ_shift_reg_shift_core.sv | 27 ++
 rtl/univ_shift_reg.sv | 95 +++++++++
 tb/tb_univ_shift_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared mode and FSM state encodings for the universal shift register.
package univ_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_reg_shift_core.sv
// Combinational next-value function of the register, shared by manual and burst paths.
module shift_core
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHR:  q_next = {si_r, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], si_l};
      MODE_LOAD: q_next = pin;
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      default:   q_next = q;  // hold and the two reserved codes
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a burst engine that repeats a latched operation N times.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [2:0]       mode_l, mode_l_next;
  logic [2:0]       core_mode;
  logic             done_next;
  logic             q_en;
  logic [WIDTH-1:0] q_next;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .q      (q),
    .mode   (core_mode),
    .si_r   (si_r),
    .si_l   (si_l),
    .pin    (pin),
    .q_next (q_next)
  );

  // The burst-accept edge leaves q untouched; only manual edges and BUSY edges update it.
  always_comb begin
    state_next  = state;
    count_next  = count;
    mode_l_next = mode_l;
    done_next   = 1'b0;
    q_en        = 1'b0;
    core_mode   = mode;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (nshift == '0) begin
            done_next = 1'b1;
          end else begin
            mode_l_next = mode;
            count_next  = nshift;
            state_next  = ST_BUSY;
          end
        end else begin
          q_en = 1'b1;
        end
      end
      ST_BUSY: begin
        core_mode  = mode_l;
        q_en       = 1'b1;
        count_next = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mode_l <= MODE_HOLD;
      done   <= 1'b0;
      q      <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      mode_l <= mode_l_next;
      done   <= done_next;
      if (q_en) q <= q_next;
    end
  end

  assign busy = (state == ST_BUSY);
  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): arithmetic reference model checked every cycle plus literal checkpoints.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       si_r = 1'b0;
  logic       si_l = 1'b0;
  logic [7:0] pin = 8'h00;
  logic       start = 1'b0;
  logic [3:0] nshift = 4'd0;
  logic [7:0] q;
  logic       so_r, so_l, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .si_r(si_r), .si_l(si_l), .pin(pin),
    .start(start), .nshift(nshift), .q(q), .so_r(so_r), .so_l(so_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: value arithmetic on integers, burst tracked as "operations remaining".
  logic [7:0] m_q = 8'h00;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_rem = 0;
  logic [2:0] m_mode = 3'd0;

  function automatic logic [7:0] apply(input logic [2:0] op, input logic [7:0] v,
                                       input logic sr, input logic sl, input logic [7:0] p);
    case (op)
      3'd1:    return (v >> 1) | (8'(sr) << 7);
      3'd2:    return (v << 1) | 8'(sl);
      3'd3:    return p;
      3'd4:    return (v >> 1) | ((v & 8'h01) << 7);
      3'd5:    return (v << 1) | (v >> 7);
      default: return v;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_q = apply(m_mode, m_q, si_r, si_l, pin);
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (nshift == 4'd0) m_done = 1'b1;
        else begin
          m_mode = mode; m_rem = int'(nshift); m_busy = 1'b1;
        end
      end else begin
        m_q = apply(mode, m_q, si_r, si_l, pin);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("q", q, m_q);
      chk("so_r", 8'(so_r), m_q & 8'h01);
      chk("so_l", 8'(so_l), m_q >> 7);
      chk("busy", 8'(busy), 8'(m_busy));
      chk("done", 8'(done), 8'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'd3; pin = v; start = 1'b0;
    tick();
    mode = 3'd0;
  endtask

  initial begin
    // 1: asynchronous reset mid-cycle
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_so_r", 8'(so_r), 8'h00);
    chk("rst_so_l", 8'(so_l), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_done", 8'(done), 8'h00);
    tick();
    rst = 1'b0;
    chk_on = 1'b1;

    // 2: manual load, shift right, shift left
    load(8'hA5);
    chk("man_load", q, 8'hA5);
    mode = 3'd1; si_r = 1'b1; tick();
    chk("man_shr", q, 8'hD2);
    chk("man_shr_so_r", 8'(so_r), 8'h00);
    mode = 3'd2; si_l = 1'b1; tick();
    chk("man_shl", q, 8'hA5);
    si_r = 1'b0; si_l = 1'b0;

    // reserved modes hold
    mode = 3'd6; tick();
    mode = 3'd7; tick();
    chk("reserved_hold", q, 8'hA5);

    // 3: burst rotate-left x3
    load(8'h81);
    mode = 3'd5; start = 1'b1; nshift = 4'd3; tick();
    start = 1'b0; mode = 3'd0;
    chk("b3_accept_q", q, 8'h81);
    chk("b3_accept_busy", 8'(busy), 8'h01);
    tick(); chk("b3_step1", q, 8'h03);
    tick(); chk("b3_step2", q, 8'h06);
    tick();
    chk("b3_final", q, 8'h0C);
    chk("b3_done", 8'(done), 8'h01);
    chk("b3_busy_low", 8'(busy), 8'h00);
    tick(); chk("b3_done_clear", 8'(done), 8'h00);

    // 4: zero-length burst
    load(8'h3C);
    start = 1'b1; nshift = 4'd0; tick();
    start = 1'b0;
    chk("z_done", 8'(done), 8'h01);
    chk("z_busy", 8'(busy), 8'h00);
    tick();
    chk("z_done_clear", 8'(done), 8'h00);
    chk("z_q", q, 8'h3C);

    // 5: reset aborts a burst
    load(8'hFF);
    mode = 3'd1; si_r = 1'b0; start = 1'b1; nshift = 4'd5; tick();
    start = 1'b0; mode = 3'd0;
    tick(); tick();
    chk("abort_pre", q, 8'h3F);
    #1 rst = 1'b1;
    #1;
    chk("abort_q", q, 8'h00);
    chk("abort_busy", 8'(busy), 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_idle_busy", 8'(busy), 8'h00);
    chk("abort_no_done", 8'(done), 8'h00);

    // 6: inputs ignored during a burst
    load(8'h01);
    mode = 3'd2; si_l = 1'b0; start = 1'b1; nshift = 4'd4; tick();
    mode = 3'd3; pin = 8'hFF; start = 1'b1; tick();
    start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0; mode = 3'd0; tick();
    chk("iso_final", q, 8'h10);
    chk("iso_done", 8'(done), 8'h01);
    tick();
    chk("iso_no_rerun", 8'(busy), 8'h00);
    chk("iso_hold", q, 8'h10);

    // long burst beyond WIDTH: 15 rotate-rights return to a 1-step-left image
    load(8'h96);
    mode = 3'd4; start = 1'b1; nshift = 4'd15; tick();
    start = 1'b0; mode = 3'd0;
    repeat (15) tick();
    chk("long_final", q, 8'h2D);
    chk("long_done", 8'(done), 8'h01);

    // burst of shift-right with live serial input
    load(8'h00);
    mode = 3'd1; si_r = 1'b1; start = 1'b1; nshift = 4'd2; tick();
    start = 1'b0; mode = 3'd0;
    tick(); si_r = 1'b0; tick();
    chk("live_si", q, 8'h40);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
